// File: rtl/riscv_pkg.sv
// Types and constants shared by the fetch unit and the opcode decoder.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fifo_fetch.sv
// Two-entry synchronous queue of fetched {instr, pc} pairs; head is a register read.
module fifo_fetch
  import riscv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign do_pop  = pop && !empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_instrucciones.sv
// Instruction fetch: PC, credit-limited memory requests, in-order response tagging and
// redirect flush. Define FETCH_ALIGN_CHK_EN to trap misaligned redirects (fault_o, HALT).
//
// state   | meaning
// ST_RUN  | normal fetching
// ST_HALT | misaligned redirect seen; no more requests until reset
module fetch_instrucciones #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic            fault_o
`endif
);

  import riscv_pkg::*;

`ifdef FETCH_ALIGN_CHK_EN
  typedef enum logic {ST_RUN, ST_HALT} state_t;
`else
  typedef enum logic {ST_RUN} state_t;
`endif

  state_t          state_q;
  logic            fetch_en_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [1:0]      outstanding_q;
  logic [1:0]      drop_q;
  logic [XLEN-1:0] tag_q [2];
  logic            tag_wr_q;
  logic            tag_rd_q;

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            pop;
  logic            grant;
  logic [1:0]      occupancy;
  logic [2:0]      slots_in_use;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_wdata;

  assign valid_o   = !fifo_empty;
  assign pop       = valid_o && ready_i;
  assign occupancy = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);

  // A word leaving the FIFO this cycle frees its slot, which sustains one fetch per cycle.
  assign slots_in_use = 3'(outstanding_q) + 3'(occupancy) - 3'(pop);

  assign imem_req_o  = fetch_en_q && (state_q == ST_RUN) && (slots_in_use < 3'd2);
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  assign fifo_push        = imem_rvalid_i && (drop_q == 2'd0) && !redirect_i
                            && (state_q == ST_RUN);
  assign fifo_wdata.instr = imem_rdata_i;
  assign fifo_wdata.pc    = tag_q[tag_rd_q];

  fifo_fetch u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .pop    (pop),
    .flush  (redirect_i),
    .wdata  (fifo_wdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  assign instr_o  = fifo_head.instr;
  assign pc_o     = fifo_head.pc;
  assign opcode_o = fifo_head.instr[6:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_RUN;
      fetch_en_q    <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      tag_q[0]      <= '0;
      tag_q[1]      <= '0;
      tag_wr_q      <= 1'b0;
      tag_rd_q      <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      fault_o       <= 1'b0;
`endif
    end else begin
      fetch_en_q    <= 1'b1;
      outstanding_q <= outstanding_q + 2'(grant) - 2'(imem_rvalid_i);
      // Tags follow every request, dropped or not, so they stay aligned with responses.
      if (grant) begin
        tag_q[tag_wr_q] <= fetch_pc_q;
        tag_wr_q        <= ~tag_wr_q;
      end
      if (imem_rvalid_i) begin
        tag_rd_q <= ~tag_rd_q;
      end
      if (redirect_i) begin
        fetch_pc_q <= align_word(redirect_pc_i);
        drop_q     <= outstanding_q - 2'(imem_rvalid_i) + 2'(grant);
`ifdef FETCH_ALIGN_CHK_EN
        if (redirect_pc_i[1:0] != 2'b00) begin
          state_q <= ST_HALT;
          fault_o <= 1'b1;
        end
`endif
      end else begin
        if (grant) begin
          fetch_pc_q <= fetch_pc_q + XLEN'(4);
        end
        if (imem_rvalid_i && (drop_q != 2'd0)) begin
          drop_q <= drop_q - 2'd1;
        end
      end
    end
  end

endmodule
